// File: rtl/memory_access.sv
// Pipeline MEM stage: request/ack data-memory transaction with store lane steering and load extension.
// Optional define MEM_ALIGN_CHECK_EN turns misaligned half/word accesses into a one-cycle flagged no-op.
module memory_access (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_co_pype2,
    input  logic [31:0] read_data2_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic [2:0]  writeback_control_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [1:0]  dsize_pype2,
    input  logic [2:0]  funct3_pype2,
    input  logic [31:0] PCp4_pype2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data_pype3,
    output logic [31:0] ALU_co_pype3,
    output logic [31:0] PCp4_pype3,
    output logic [4:0]  WReg_pype3,
    output logic [2:0]  writeback_control_pype3,
    output logic        mem_misalign
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t      state;
    logic [1:0]  lat_a;
    logic [2:0]  lat_funct3;
    logic        lat_load;
    logic [31:0] hold_data;

    logic        mem_op;
    logic        misaligned;
    logic        start_op;
    logic        is_store;
    logic [1:0]  eff_a;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext_data;

    assign mem_op   = |MemRW_pype2;
    assign is_store = MemRW_pype2[0];

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = mem_op &&
                        (((dsize_pype2 == 2'b01) && ALU_co_pype2[0]) ||
                         (dsize_pype2[1] && (ALU_co_pype2[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign start_op  = mem_op && !misaligned;
    assign mem_stall = ((state == IDLE) && start_op) || (state == BUSY);

    // Half/word offsets are forced aligned; a no-op for aligned addresses.
    always_comb begin
        eff_a    = ALU_co_pype2[1:0];
        st_be    = 4'b1111;
        st_wdata = read_data2_pype2;
        case (dsize_pype2)
            2'b00: begin
                st_be    = 4'b0001 << eff_a;
                st_wdata = {4{read_data2_pype2[7:0]}};
            end
            2'b01: begin
                eff_a[0] = 1'b0;
                st_be    = eff_a[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{read_data2_pype2[15:0]}};
            end
            default: eff_a = 2'b00;
        endcase
    end

    always_comb begin
        case (lat_a)
            2'd0:    byte_sel = dmem_rdata[7:0];
            2'd1:    byte_sel = dmem_rdata[15:8];
            2'd2:    byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = lat_a[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (lat_funct3)
            3'b000:  ext_data = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  ext_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  ext_data = {24'd0, byte_sel};
            3'b101:  ext_data = {16'd0, half_sel};
            default: ext_data = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= IDLE;
            dmem_req                <= 1'b0;
            dmem_we                 <= 1'b0;
            dmem_addr               <= 32'd0;
            dmem_wdata              <= 32'd0;
            dmem_be                 <= 4'd0;
            lat_a                   <= 2'd0;
            lat_funct3              <= 3'd0;
            lat_load                <= 1'b0;
            hold_data               <= 32'd0;
            load_data_pype3         <= 32'd0;
            ALU_co_pype3            <= 32'd0;
            PCp4_pype3              <= 32'd0;
            WReg_pype3              <= 5'd0;
            writeback_control_pype3 <= 3'd0;
`ifdef MEM_ALIGN_CHECK_EN
            mem_misalign            <= 1'b0;
`endif
        end else begin
`ifdef MEM_ALIGN_CHECK_EN
            mem_misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start_op) begin
                        state      <= BUSY;
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {ALU_co_pype2[31:2], 2'b00};
                        dmem_wdata <= is_store ? st_wdata : 32'd0;
                        dmem_be    <= is_store ? st_be : 4'b1111;
                        lat_a      <= eff_a;
                        lat_funct3 <= funct3_pype2;
                        lat_load   <= !is_store;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        hold_data <= ext_data;
                        dmem_req  <= 1'b0;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Stalled cycles push a bubble into MEM/WB; otherwise the op retires.
            if (mem_stall) begin
                load_data_pype3         <= 32'd0;
                ALU_co_pype3            <= 32'd0;
                PCp4_pype3              <= 32'd0;
                WReg_pype3              <= 5'd0;
                writeback_control_pype3 <= 3'd0;
            end else begin
                load_data_pype3         <= ((state == DONE) && lat_load) ? hold_data : 32'd0;
                ALU_co_pype3            <= ALU_co_pype2;
                PCp4_pype3              <= PCp4_pype2;
                WReg_pype3              <= WReg_pype2;
                writeback_control_pype3 <= writeback_control_pype2;
`ifdef MEM_ALIGN_CHECK_EN
                if (misaligned) begin
                    writeback_control_pype3 <= 3'd0;
                    mem_misalign            <= 1'b1;
                end
`endif
            end
        end
    end

`ifndef MEM_ALIGN_CHECK_EN
    assign mem_misalign = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed testbench for memory_access with a small reactive bus responder.
// Expectations switch on MEM_ALIGN_CHECK_EN for the misaligned-access case.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ALU_co_pype2, read_data2_pype2, PCp4_pype2;
    logic [4:0]  WReg_pype2;
    logic [2:0]  writeback_control_pype2, funct3_pype2;
    logic [1:0]  MemRW_pype2, dsize_pype2;
    logic        dmem_req, dmem_we, dmem_ack, mem_stall, mem_misalign;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] load_data_pype3, ALU_co_pype3, PCp4_pype3;
    logic [4:0]  WReg_pype3;
    logic [2:0]  writeback_control_pype3;

    int checkCount = 0;
    int errorCount = 0;

    int          stalls, reqCycles, bubbleErr;
    logic [31:0] firstAddr, firstWdata;
    logic [3:0]  firstBe;
    logic        firstWe;

    memory_access dut (
        .clk(clk), .rst(rst),
        .ALU_co_pype2(ALU_co_pype2), .read_data2_pype2(read_data2_pype2),
        .WReg_pype2(WReg_pype2), .writeback_control_pype2(writeback_control_pype2),
        .MemRW_pype2(MemRW_pype2), .dsize_pype2(dsize_pype2),
        .funct3_pype2(funct3_pype2), .PCp4_pype2(PCp4_pype2),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .load_data_pype3(load_data_pype3), .ALU_co_pype3(ALU_co_pype3),
        .PCp4_pype3(PCp4_pype3), .WReg_pype3(WReg_pype3),
        .writeback_control_pype3(writeback_control_pype3),
        .mem_misalign(mem_misalign)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [4:0] wreg, input logic [2:0] wbc,
                                 input logic [1:0] memrw, input logic [1:0] dsize,
                                 input logic [2:0] f3, input logic [31:0] pcp4);
        ALU_co_pype2            = addr;
        read_data2_pype2        = data;
        WReg_pype2              = wreg;
        writeback_control_pype2 = wbc;
        MemRW_pype2             = memrw;
        dsize_pype2             = dsize;
        funct3_pype2            = f3;
        PCp4_pype2              = pcp4;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one memory op from IDLE to retirement; acks on the ackAfter-th request cycle
    // and drives a stray ack with junk data whenever no request is pending.
    task automatic runMemOp(input int ackAfter, input logic [31:0] rdata);
        int  busy;
        bit  done;
        busy = 0; done = 0;
        stalls = 0; reqCycles = 0; bubbleErr = 0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (cyc > 0 && (WReg_pype3 != 5'd0 || writeback_control_pype3 != 3'd0 || ALU_co_pype3 != 32'd0))
                bubbleErr++;
            if (dmem_req) begin
                busy++;
                reqCycles++;
                if (busy == 1) begin
                    firstAddr = dmem_addr; firstWdata = dmem_wdata;
                    firstBe = dmem_be; firstWe = dmem_we;
                end
                dmem_ack   = (busy == ackAfter);
                dmem_rdata = dmem_ack ? rdata : 32'hDEADBEEF;
            end else begin
                dmem_ack   = 1'b1;
                dmem_rdata = 32'hDEADBEEF;
            end
            if (mem_stall) stalls++;
            else done = 1;
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
        end
        checkOutput("op_completed", {31'd0, done}, 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        applyStimulus(32'd0, 32'd0, 5'd0, 3'd0, 2'b00, 2'b00, 3'd0, 32'd0);
        #12;
        checkOutput("rst_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("rst_be", {28'd0, dmem_be}, 32'd0);
        checkOutput("rst_addr", dmem_addr, 32'd0);
        checkOutput("rst_load", load_data_pype3, 32'd0);
        checkOutput("rst_wreg", {27'd0, WReg_pype3}, 32'd0);
        checkOutput("rst_stall", {31'd0, mem_stall}, 32'd0);
        checkOutput("rst_misalign", {31'd0, mem_misalign}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // SB at 0x1003, single-cycle ack
        applyStimulus(32'h1003, 32'h000000A5, 5'd5, 3'b010, 2'b01, 2'b00, 3'b000, 32'h104);
        runMemOp(1, 32'h0);
        checkOutput("sb_stalls", stalls, 32'd2);
        checkOutput("sb_addr", firstAddr, 32'h1000);
        checkOutput("sb_be", {28'd0, firstBe}, 32'h8);
        checkOutput("sb_wdata", firstWdata, 32'hA5A5A5A5);
        checkOutput("sb_we", {31'd0, firstWe}, 32'd1);
        checkOutput("sb_wreg", {27'd0, WReg_pype3}, 32'd5);
        checkOutput("sb_wbc", {29'd0, writeback_control_pype3}, 32'd2);
        checkOutput("sb_load", load_data_pype3, 32'd0);

        // SH encoded as MemRW=11 at 0x1002
        applyStimulus(32'h1002, 32'h0000BEEF, 5'd6, 3'b000, 2'b11, 2'b01, 3'b001, 32'h108);
        runMemOp(2, 32'h0);
        checkOutput("sh_we", {31'd0, firstWe}, 32'd1);
        checkOutput("sh_be", {28'd0, firstBe}, 32'hC);
        checkOutput("sh_wdata", firstWdata, 32'hBEEFBEEF);
        checkOutput("sh_reqs", reqCycles, 32'd2);

        // LB at 0x2001, ack after 3 busy cycles
        applyStimulus(32'h2001, 32'h0, 5'd10, 3'b101, 2'b10, 2'b00, 3'b000, 32'h10C);
        runMemOp(3, 32'h0000F000);
        checkOutput("lb_stalls", stalls, 32'd4);
        checkOutput("lb_reqs", reqCycles, 32'd3);
        checkOutput("lb_bubbles", bubbleErr, 32'd0);
        checkOutput("lb_be", {28'd0, firstBe}, 32'hF);
        checkOutput("lb_we", {31'd0, firstWe}, 32'd0);
        checkOutput("lb_data", load_data_pype3, 32'hFFFFFFF0);
        checkOutput("lb_wreg", {27'd0, WReg_pype3}, 32'd10);

        // LHU then LH back to back
        applyStimulus(32'h2002, 32'h0, 5'd11, 3'b101, 2'b10, 2'b01, 3'b101, 32'h110);
        runMemOp(2, 32'h80011234);
        checkOutput("lhu_data", load_data_pype3, 32'h00008001);
        checkOutput("lhu_reqs", reqCycles, 32'd2);
        applyStimulus(32'h2002, 32'h0, 5'd12, 3'b101, 2'b10, 2'b01, 3'b001, 32'h114);
        runMemOp(1, 32'h80011234);
        checkOutput("lh_data", load_data_pype3, 32'hFFFF8001);
        checkOutput("lh_stalls", stalls, 32'd2);

        // ADD then LW
        applyStimulus(32'h55, 32'h0, 5'd7, 3'b101, 2'b00, 2'b00, 3'b000, 32'h200);
        #1;
        checkOutput("add_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        checkOutput("add_alu", ALU_co_pype3, 32'h55);
        checkOutput("add_wreg", {27'd0, WReg_pype3}, 32'd7);
        checkOutput("add_pc", PCp4_pype3, 32'h200);
        applyStimulus(32'h4000, 32'h0, 5'd8, 3'b101, 2'b10, 2'b10, 3'b010, 32'h204);
        runMemOp(1, 32'h12345678);
        checkOutput("lw_stalls", stalls, 32'd2);
        checkOutput("lw_data", load_data_pype3, 32'h12345678);
        checkOutput("lw_alu", ALU_co_pype3, 32'h4000);

        // LW at misaligned 0x3002
        applyStimulus(32'h3002, 32'h0, 5'd9, 3'b101, 2'b10, 2'b10, 3'b010, 32'h208);
`ifdef MEM_ALIGN_CHECK_EN
        #1;
        checkOutput("mis_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        checkOutput("mis_flag", {31'd0, mem_misalign}, 32'd1);
        checkOutput("mis_wbc", {29'd0, writeback_control_pype3}, 32'd0);
        checkOutput("mis_req", {31'd0, dmem_req}, 32'd0);
        applyStimulus(32'h0, 32'h0, 5'd0, 3'd0, 2'b00, 2'b00, 3'd0, 32'h20C);
        tick();
        checkOutput("mis_flag_clear", {31'd0, mem_misalign}, 32'd0);
`else
        runMemOp(1, 32'hCAFEF00D);
        checkOutput("mis_addr", firstAddr, 32'h3000);
        checkOutput("mis_data", load_data_pype3, 32'hCAFEF00D);
        checkOutput("mis_flag", {31'd0, mem_misalign}, 32'd0);
`endif

        // Reset while BUSY
        applyStimulus(32'h4004, 32'h0, 5'd9, 3'b101, 2'b10, 2'b10, 3'b010, 32'h210);
        tick();
        checkOutput("busy_req", {31'd0, dmem_req}, 32'd1);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h0BADF00D;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_req_drop", {31'd0, dmem_req}, 32'd0);
        applyStimulus(32'h0, 32'h0, 5'd0, 3'd0, 2'b00, 2'b00, 3'd0, 32'h0);
        dmem_ack = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        checkOutput("post_rst_stall", {31'd0, mem_stall}, 32'd0);
        checkOutput("post_rst_addr", dmem_addr, 32'd0);
        checkOutput("post_rst_load", load_data_pype3, 32'd0);
        checkOutput("post_rst_wreg", {27'd0, WReg_pype3}, 32'd0);
        tick();
        checkOutput("post_rst_idle_req", {31'd0, dmem_req}, 32'd0);
        checkOutput("post_rst_idle_stall", {31'd0, mem_stall}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
